// File: rtl/vga_timing_out.sv
// Pixel-rate VGA timing generator with a matched sync/blank delay line and a
// registered PMOD output word {hsync,B0,G0,R0,vsync,B1,G1,R1}.
module vga_timing_out #(
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned PIPE_DELAY      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [5:0] rgb_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] uo_out
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast = 10'(HTotal - 1);
  localparam logic [9:0] VLast = 10'(VTotal - 1);

  // 11-bit bounds so a sync pulse ending exactly at 1024 does not wrap to 0.
  localparam logic [10:0] HVis        = 11'(H_VISIBLE);
  localparam logic [10:0] VVis        = 11'(V_VISIBLE);
  localparam logic [10:0] HSyncStart  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncEnd    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VSyncStart  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VSyncEnd    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic       SyncIdle = (SYNC_ACTIVE_LOW != 0);
  localparam logic [7:0] UoReset  = {SyncIdle, 3'b000, SyncIdle, 3'b000};

  logic [9:0]  hpos_q, vpos_q;
  logic [10:0] hpos_ext, vpos_ext;
  logic        hsync_raw, vsync_raw;
  logic [2:0]  stage_in, stage_out;
  logic [5:0]  rgb_masked;
  logic        hsync_out, vsync_out;
  logic [7:0]  uo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else if (ena) begin
      if (hpos_q == HLast) begin
        hpos_q <= '0;
        vpos_q <= (vpos_q == VLast) ? '0 : vpos_q + 10'd1;
      end else begin
        hpos_q <= hpos_q + 10'd1;
      end
    end
  end

  assign hpos_ext = {1'b0, hpos_q};
  assign vpos_ext = {1'b0, vpos_q};

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign display_on  = (hpos_ext < HVis) && (vpos_ext < VVis);
  assign line_start  = (hpos_q == 10'd0);
  assign frame_start = line_start && (vpos_q == 10'd0);

  assign hsync_raw = (hpos_ext >= HSyncStart) && (hpos_ext < HSyncEnd);
  assign vsync_raw = (vpos_ext >= VSyncStart) && (vpos_ext < VSyncEnd);

  // Delay-line payload {hsync, vsync, display_on}; syncs are active-high here.
  assign stage_in = {hsync_raw, vsync_raw, display_on};

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign stage_out = stage_in;
    end else begin : g_pipe
      logic [2:0] pipe_q [PIPE_DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= '0;
          end
        end else if (ena) begin
          pipe_q[0] <= stage_in;
          for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign stage_out = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign rgb_masked = stage_out[0] ? rgb_in : 6'd0;
  assign hsync_out  = stage_out[2] ^ SyncIdle;
  assign vsync_out  = stage_out[1] ^ SyncIdle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q <= UoReset;
    end else if (ena) begin
      uo_q <= {hsync_out, rgb_masked[0], rgb_masked[2], rgb_masked[4],
               vsync_out, rgb_masked[1], rgb_masked[3], rgb_masked[5]};
    end
  end

  assign uo_out = uo_q;

endmodule
